cpu_seq_ctrl: RTL and testbench

Multi-cycle instruction sequencer for the mini_cpu core. It fetches an instruction into the instruction register, which drives the instruction decoder. It then steps execute, memory and writeback according to the decoder's control outputs, updates the PC and counts retired instructions. It traps and halts on an illegal opcode or a bus timeout.

---
 rtl/cpu_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb sequencer for mini_cpu
module cpu_seq_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] ir_o,
   input  logic        branch_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic        reg_write_i,
   input  logic        valid_inst_i,
   input  logic [1:0]  jump_i,
   input  logic        branch_taken_i,
   input  logic [31:0] target_pc_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   input  logic        dmem_ack_i,
   output logic        rf_we_o,
   output logic [31:0] pc_o,
   output logic [31:0] instret_o,
   output logic        halt_o,
   output logic [1:0]  trap_cause_o
);

   localparam logic [7:0] TIMEOUT = 8'(ACK_TIMEOUT);

   typedef enum logic [2:0] {
      S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_e;

   state_e      state_q;
   logic [31:0] pc_q, ir_q, instret_q, tgt_q;
   logic        take_q, imem_req_q, dmem_req_q, dmem_we_q, rf_we_q, halt_q;
   logic [1:0]  cause_q;
   logic [7:0]  wait_q;

   logic        take_d;
   logic [7:0]  wait_d;
   logic [31:0] pc_exec_d, pc_late_d, pc_seq_d;

   assign take_d    = (jump_i != 2'b00) | (branch_i & branch_taken_i);
   assign wait_d    = wait_q + 8'd1;
   assign pc_seq_d  = pc_q + 32'd4;
   // EXEC retires with live ALU values; MEM/WB retire with the ones latched in EXEC
   assign pc_exec_d = take_d ? {target_pc_i[31:1], 1'b0} : pc_seq_d;
   assign pc_late_d = take_q ? {tgt_q[31:1], 1'b0} : pc_seq_d;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_BOOT;
         pc_q       <= RESET_PC;
         ir_q       <= 32'h0;
         instret_q  <= 32'h0;
         tgt_q      <= 32'h0;
         take_q     <= 1'b0;
         imem_req_q <= 1'b0;
         dmem_req_q <= 1'b0;
         dmem_we_q  <= 1'b0;
         rf_we_q    <= 1'b0;
         halt_q     <= 1'b0;
         cause_q    <= 2'b00;
         wait_q     <= 8'h0;
      end else begin
         rf_we_q <= 1'b0;
         case (state_q)
            S_BOOT: begin
               imem_req_q <= 1'b1;
               wait_q     <= 8'h0;
               state_q    <= S_FETCH;
            end
            S_FETCH: begin
               if (imem_ack_i) begin
                  ir_q       <= imem_rdata_i;
                  imem_req_q <= 1'b0;
                  wait_q     <= 8'h0;
                  state_q    <= S_DECODE;
               end else if (wait_d == TIMEOUT) begin
                  imem_req_q <= 1'b0;
                  halt_q     <= 1'b1;
                  cause_q    <= 2'b10;
                  wait_q     <= wait_d;
                  state_q    <= S_TRAP;
               end else begin
                  wait_q <= wait_d;
               end
            end
            S_DECODE: begin
               if (!valid_inst_i) begin
                  halt_q  <= 1'b1;
                  cause_q <= 2'b01;
                  state_q <= S_TRAP;
               end else begin
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               take_q <= take_d;
               tgt_q  <= target_pc_i;
               if (mem_read_i | mem_write_i) begin
                  dmem_req_q <= 1'b1;
                  dmem_we_q  <= mem_write_i;
                  wait_q     <= 8'h0;
                  state_q    <= S_MEM;
               end else if (reg_write_i) begin
                  rf_we_q <= 1'b1;
                  state_q <= S_WB;
               end else begin
                  pc_q       <= pc_exec_d;
                  instret_q  <= instret_q + 32'd1;
                  imem_req_q <= 1'b1;
                  wait_q     <= 8'h0;
                  state_q    <= S_FETCH;
               end
            end
            S_MEM: begin
               if (dmem_ack_i) begin
                  dmem_req_q <= 1'b0;
                  dmem_we_q  <= 1'b0;
                  wait_q     <= 8'h0;
                  if (mem_read_i) begin
                     rf_we_q <= 1'b1;
                     state_q <= S_WB;
                  end else begin
                     pc_q       <= pc_late_d;
                     instret_q  <= instret_q + 32'd1;
                     imem_req_q <= 1'b1;
                     state_q    <= S_FETCH;
                  end
               end else if (wait_d == TIMEOUT) begin
                  dmem_req_q <= 1'b0;
                  dmem_we_q  <= 1'b0;
                  halt_q     <= 1'b1;
                  cause_q    <= 2'b11;
                  wait_q     <= wait_d;
                  state_q    <= S_TRAP;
               end else begin
                  wait_q <= wait_d;
               end
            end
            S_WB: begin
               pc_q       <= pc_late_d;
               instret_q  <= instret_q + 32'd1;
               imem_req_q <= 1'b1;
               wait_q     <= 8'h0;
               state_q    <= S_FETCH;
            end
            default: begin
               // TRAP holds everything until reset
               state_q <= S_TRAP;
            end
         endcase
      end
   end

   assign imem_req_o   = imem_req_q;
   assign imem_addr_o  = pc_q;
   assign ir_o         = ir_q;
   assign dmem_req_o   = dmem_req_q;
   assign dmem_we_o    = dmem_we_q;
   assign rf_we_o      = rf_we_q;
   assign pc_o         = pc_q;
   assign instret_o    = instret_q;
   assign halt_o       = halt_q;
   assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb/tb_cpu_seq_ctrl.sv - self-checking bench for cpu_seq_ctrl
module tb_cpu_seq_ctrl;

   localparam logic [31:0] RPC = 32'h0000_0100;
   localparam int          TO  = 4;
   localparam int          NEVER = 255;
   localparam logic [2:0]  C_ALU = 3'd0, C_BR = 3'd1, C_LD = 3'd2, C_ST = 3'd3,
                           C_JAL = 3'd4, C_JALR = 3'd5, C_ILL = 3'd6;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        imem_req_o, imem_ack_i, dmem_req_o, dmem_we_o, dmem_ack_i, rf_we_o, halt_o;
   logic [31:0] imem_addr_o, imem_rdata_i, ir_o, target_pc_i, pc_o, instret_o;
   logic        branch_i, mem_read_i, mem_write_i, reg_write_i, valid_inst_i, branch_taken_i;
   logic [1:0]  jump_i, trap_cause_o;

   cpu_seq_ctrl #(.RESET_PC(RPC), .ACK_TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
      .imem_rdata_i(imem_rdata_i), .ir_o(ir_o),
      .branch_i(branch_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .reg_write_i(reg_write_i), .valid_inst_i(valid_inst_i), .jump_i(jump_i),
      .branch_taken_i(branch_taken_i), .target_pc_i(target_pc_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
      .rf_we_o(rf_we_o), .pc_o(pc_o), .instret_o(instret_o),
      .halt_o(halt_o), .trap_cause_o(trap_cause_o)
   );

   always #5 clk_i = ~clk_i;

   // Bench-side decoder: instruction class lives in ir[2:0]
   assign valid_inst_i = (ir_o[2:0] < 3'd6);
   assign branch_i     = (ir_o[2:0] == C_BR);
   assign mem_read_i   = (ir_o[2:0] == C_LD);
   assign mem_write_i  = (ir_o[2:0] == C_ST);
   assign reg_write_i  = (ir_o[2:0] == C_ALU) || (ir_o[2:0] == C_LD) ||
                         (ir_o[2:0] == C_JAL) || (ir_o[2:0] == C_JALR);
   assign jump_i       = (ir_o[2:0] == C_JAL) ? 2'd1 : (ir_o[2:0] == C_JALR) ? 2'd2 : 2'd0;

   typedef struct {
      logic [2:0]  cls;
      logic        taken;
      logic [31:0] tgt;
      int          idelay;
      int          ddelay;
      int          exp_cyc;
      int          exp_rf;
      logic [1:0]  exp_cause;
      int          exp_dcyc;
   } vec_t;

   int          n_vec = 0;
   int          n_miss = 0;
   logic [31:0] exp_pc, exp_instret, last_ir;
   vec_t        tbl[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void model(input vec_t v, output int cyc, output int rf,
                                 output logic [1:0] cause, output int dcyc);
      int f;
      rf = 0; dcyc = 0; cause = 2'b00;
      if (v.idelay >= TO) begin cyc = TO; cause = 2'b10; return; end
      f = v.idelay + 1;
      if (v.cls >= C_ILL) begin cyc = f + 1; cause = 2'b01; return; end
      if (v.cls == C_LD || v.cls == C_ST) begin
         if (v.ddelay >= TO) begin cyc = f + 2 + TO; dcyc = TO; cause = 2'b11; return; end
         dcyc = v.ddelay + 1;
         cyc  = f + 2 + dcyc + ((v.cls == C_LD) ? 1 : 0);
         rf   = (v.cls == C_LD) ? 1 : 0;
         return;
      end
      cyc = (v.cls == C_BR) ? f + 2 : f + 3;
      rf  = (v.cls == C_BR) ? 0 : 1;
   endfunction

   task automatic do_reset();
      @(negedge clk_i);
      rst_n_i = 1'b0; imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
      #1;
      check("rst_async_imem_req", imem_req_o, 0);
      check("rst_async_dmem_req", dmem_req_o, 0);
      repeat (2) @(negedge clk_i);
      check("rst_pc", pc_o, RPC);
      check("rst_ir", ir_o, 0);
      check("rst_instret", instret_o, 0);
      check("rst_outs", {imem_req_o, dmem_req_o, dmem_we_o, rf_we_o, halt_o, trap_cause_o}, 0);
      rst_n_i = 1'b1;
      @(negedge clk_i);
      check("boot_imem_req", imem_req_o, 1);
      check("boot_imem_addr", imem_addr_o, RPC);
      exp_pc = RPC; exp_instret = 0; last_ir = 0;
   endtask

   // Starts in the first FETCH cycle; ends in the next FETCH cycle or once halted
   task automatic run_instr(input vec_t v, input int e_cyc, input int e_rf,
                            input logic [1:0] e_cause, input int e_dcyc);
      logic [31:0] instr;
      int c = 0, fcnt = 0, dcnt = 0, rf = 0, dcyc = 0, lowcnt = 0;
      bit seen_low = 0, done = 0, we_bad = 0;
      logic take;
      instr = $urandom();
      instr[2:0] = v.cls;
      imem_rdata_i = instr;
      check("fetch_addr", imem_addr_o, exp_pc);
      for (int g = 0; g < 64 && !done; g++) begin
         if (halt_o || (imem_req_o && seen_low)) begin
            done = 1;
         end else begin
            c++;
            if (!imem_req_o) begin seen_low = 1; lowcnt++; end
            // ALU results are only guaranteed in EXEC; scramble them elsewhere
            target_pc_i    = (lowcnt == 2) ? v.tgt : $urandom();
            branch_taken_i = (lowcnt == 2) ? v.taken : 1'($urandom());
            rf += int'(rf_we_o);
            if (dmem_req_o) begin
               dcyc++;
               if (dmem_we_o !== (v.cls == C_ST)) we_bad = 1;
            end
            imem_ack_i = imem_req_o && (fcnt == v.idelay);
            if (imem_req_o) fcnt++;
            dmem_ack_i = dmem_req_o && (dcnt == v.ddelay);
            if (dmem_req_o) dcnt++;
            @(negedge clk_i);
         end
      end
      imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
      check("cycle_budget", 32'(done), 1);
      check("cycles", c, e_cyc);
      check("rf_we_pulses", rf, e_rf);
      check("dmem_req_cycles", dcyc, e_dcyc);
      check("dmem_we_value", 32'(we_bad), 0);
      check("halt", halt_o, (e_cause != 0));
      check("trap_cause", trap_cause_o, e_cause);
      if (e_cause != 2'b10) last_ir = instr;
      check("ir", ir_o, last_ir);
      if (e_cause == 2'b00) begin
         take = (v.cls == C_JAL) || (v.cls == C_JALR) || (v.cls == C_BR && v.taken);
         exp_pc = take ? {v.tgt[31:1], 1'b0} : exp_pc + 32'd4;
         exp_instret = exp_instret + 32'd1;
      end
      check("pc", pc_o, exp_pc);
      check("instret", instret_o, exp_instret);
      if (e_cause != 2'b00) begin
         imem_rdata_i = 32'hDEAD_BEEF; imem_ack_i = 1'b1; dmem_ack_i = 1'b1;
         repeat (3) @(negedge clk_i);
         imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
         check("trap_frozen_ir", ir_o, last_ir);
         check("trap_frozen_pc", pc_o, exp_pc);
         check("trap_frozen_instret", instret_o, exp_instret);
         check("trap_sticky", {halt_o, trap_cause_o, imem_req_o, dmem_req_o, rf_we_o},
               {1'b1, e_cause, 3'b000});
         do_reset();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   cyc, rf, dcyc;
      logic [1:0] cause;
      imem_ack_i = 0; dmem_ack_i = 0; imem_rdata_i = 0;
      target_pc_i = 0; branch_taken_i = 0;
      //          cls     tk  tgt           idl    ddl    cyc rf cause dcyc
      tbl[0]  = '{C_ALU,  0, 32'h0,         0,     0,     4, 1, 2'b00, 0};
      tbl[1]  = '{C_BR,   1, 32'h40,        0,     0,     3, 0, 2'b00, 0};
      tbl[2]  = '{C_BR,   0, 32'h80,        0,     0,     3, 0, 2'b00, 0};
      tbl[3]  = '{C_LD,   0, 32'h0,         0,     3,     8, 1, 2'b00, 4};
      tbl[4]  = '{C_ST,   1, 32'h0,         0,     0,     4, 0, 2'b00, 1};
      tbl[5]  = '{C_JALR, 0, 32'h203,       0,     0,     4, 1, 2'b00, 0};
      tbl[6]  = '{C_ALU,  0, 32'h0,         3,     0,     7, 1, 2'b00, 0};
      tbl[7]  = '{C_ST,   0, 32'h0,         0,     3,     7, 0, 2'b00, 4};
      tbl[8]  = '{C_JAL,  0, 32'hFFFF_FFFC, 0,     0,     4, 1, 2'b00, 0};
      tbl[9]  = '{C_ALU,  0, 32'h0,         0,     0,     4, 1, 2'b00, 0};
      tbl[10] = '{C_LD,   0, 32'h0,         2,     1,     8, 1, 2'b00, 2};
      tbl[11] = '{C_ILL,  0, 32'h0,         0,     0,     2, 0, 2'b01, 0};
      tbl[12] = '{C_ALU,  0, 32'h0,         NEVER, 0,     4, 0, 2'b10, 0};

      do_reset();
      for (int i = 0; i < 13; i++)
         run_instr(tbl[i], tbl[i].exp_cyc, tbl[i].exp_rf, tbl[i].exp_cause, tbl[i].exp_dcyc);
      run_instr('{C_LD, 0, 32'h0, 0, NEVER, 7, 0, 2'b11, 4}, 7, 0, 2'b11, 4);

      // Reset in the middle of a data access drops dmem_req without waiting for a clock
      imem_rdata_i = {29'h0, C_LD};
      imem_ack_i = 1'b1;
      @(negedge clk_i);
      imem_ack_i = 1'b0;
      for (int g = 0; g < 8 && !dmem_req_o; g++) @(negedge clk_i);
      check("mid_dmem_req_up", dmem_req_o, 1);
      #2 rst_n_i = 1'b0;
      #1;
      check("mid_rst_dmem_req", dmem_req_o, 0);
      check("mid_rst_pc", pc_o, RPC);
      do_reset();

      for (int n = 0; n < 150; n++) begin
         v.cls    = ($urandom_range(0, 24) == 0) ? C_ILL : 3'($urandom_range(0, 5));
         v.taken  = 1'($urandom());
         v.tgt    = $urandom();
         v.idelay = ($urandom_range(0, 29) == 0) ? TO : $urandom_range(0, TO - 1);
         v.ddelay = ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, TO - 1);
         model(v, cyc, rf, cause, dcyc);
         run_instr(v, cyc, rf, cause, dcyc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
